// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: owns the shared QSPI port. Arbitrates CU instruction fetch
// (flash, cs0) against data load/store (RAM, cs1), runs the granted transaction
// through the qspi start/busy handshake, steers the controller chip-select to the
// owning device and returns read data with a one-cycle valid pulse.
module qspi_bus_arbiter #(
    parameter logic [7:0]  RAM_PAGE        = 8'h01,
    parameter logic [7:0]  ROM_PAGE        = 8'h00,
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [7:0]  f_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [7:0]  d_rdata,
    output logic        q_start,
    output logic        q_write,
    output logic [23:0] q_addr,
    output logic [7:0]  q_wdata,
    input  logic        q_busy,
    input  logic [7:0]  q_rdata,
    input  logic        q_cs,
    output logic        cs_rom,
    output logic        cs_ram,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    // Last cycle index of START+WAIT before the transaction is abandoned.
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    state_t      state_q,   state_d;
    owner_t      owner_q,   owner_d;
    logic [3:0]  streak_q,  streak_d;
    logic [7:0]  tcnt_q,    tcnt_d;
    logic [23:0] q_addr_q,  q_addr_d;
    logic        q_write_q, q_write_d;
    logic [7:0]  q_wdata_q, q_wdata_d;
    logic [7:0]  f_data_q,  f_data_d;
    logic [7:0]  d_rdata_q, d_rdata_d;
    logic        f_gnt_q,   f_gnt_d;
    logic        d_gnt_q,   d_gnt_d;
    logic        f_valid_q, f_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        err_q,     err_d;

    logic fetch_wins;
    logic timed_out;

    assign fetch_wins = f_req && (!d_req || (streak_q == STREAK_MAX));
    assign timed_out  = (tcnt_q >= TO_LAST);

    // Next-state, arbitration, transaction latching and pulse generation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        tcnt_d    = tcnt_q;
        q_addr_d  = q_addr_q;
        q_write_d = q_write_q;
        q_wdata_d = q_wdata_q;
        f_data_d  = f_data_q;
        d_rdata_d = d_rdata_q;
        f_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        f_valid_d = 1'b0;
        d_valid_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                owner_d = OWN_NONE;
                if (f_req || d_req) begin
                    state_d = S_START;
                    tcnt_d  = '0;
                    if (fetch_wins) begin
                        owner_d   = OWN_F;
                        q_addr_d  = {ROM_PAGE, f_addr};
                        q_write_d = 1'b0;
                        q_wdata_d = '0;
                        f_gnt_d   = 1'b1;
                        streak_d  = '0;
                    end else begin
                        owner_d   = OWN_D;
                        q_addr_d  = {RAM_PAGE, d_addr};
                        q_write_d = d_we;
                        q_wdata_d = d_wdata;
                        d_gnt_d   = 1'b1;
                        if (!f_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end

            // Timeout takes priority in START so the counter cannot slip past
            // its limit on the same edge that moves the FSM into WAIT.
            S_START: begin
                tcnt_d = tcnt_q + 8'd1;
                if (timed_out) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_F) begin
                        f_valid_d = 1'b1;
                        f_data_d  = 8'hFF;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!q_write_q) d_rdata_d = 8'hFF;
                    end
                end else if (q_busy) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                tcnt_d = tcnt_q + 8'd1;
                if (!q_busy) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_F) begin
                        f_valid_d = 1'b1;
                        f_data_d  = q_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!q_write_q) d_rdata_d = q_rdata;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_F) begin
                        f_valid_d = 1'b1;
                        f_data_d  = 8'hFF;
                    end else begin
                        d_valid_d = 1'b1;
                        if (!q_write_q) d_rdata_d = 8'hFF;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            streak_q  <= '0;
            tcnt_q    <= '0;
            q_addr_q  <= '0;
            q_write_q <= 1'b0;
            q_wdata_q <= '0;
            f_data_q  <= '0;
            d_rdata_q <= '0;
            f_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            tcnt_q    <= tcnt_d;
            q_addr_q  <= q_addr_d;
            q_write_q <= q_write_d;
            q_wdata_q <= q_wdata_d;
            f_data_q  <= f_data_d;
            d_rdata_q <= d_rdata_d;
            f_gnt_q   <= f_gnt_d;
            d_gnt_q   <= d_gnt_d;
            f_valid_q <= f_valid_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
        end
    end

    // Chip-select steering: only the owning device sees the controller's select.
    always_comb begin
        cs_rom = 1'b1;
        cs_ram = 1'b1;
        if (state_q != S_IDLE) begin
            if (owner_q == OWN_F) cs_rom = q_cs;
            if (owner_q == OWN_D) cs_ram = q_cs;
        end
    end

    assign q_start = (state_q == S_START);
    assign busy    = (state_q != S_IDLE);
    assign q_addr  = q_addr_q;
    assign q_write = q_write_q;
    assign q_wdata = q_wdata_q;
    assign f_data  = f_data_q;
    assign d_rdata = d_rdata_q;
    assign f_gnt   = f_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign f_valid = f_valid_q;
    assign d_valid = d_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter with a behavioural qspi controller model.
module tb_qspi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_gnt, f_valid;
    logic [7:0]  f_data;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic        d_gnt, d_valid;
    logic [7:0]  d_rdata;
    logic        q_start, q_write;
    logic [23:0] q_addr;
    logic [7:0]  q_wdata;
    logic        q_busy, q_cs;
    logic [7:0]  q_rdata;
    logic        cs_rom, cs_ram, busy, err;

    qspi_bus_arbiter #(
        .RAM_PAGE(8'h01),
        .ROM_PAGE(8'h00),
        .MAX_DATA_STREAK(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .q_start(q_start), .q_write(q_write), .q_addr(q_addr), .q_wdata(q_wdata),
        .q_busy(q_busy), .q_rdata(q_rdata), .q_cs(q_cs),
        .cs_rom(cs_rom), .cs_ram(cs_ram), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // qspi controller model: busy for mlat cycles after a sampled start, or forever while stuck.
    logic       mbusy = 1'b0;
    int         mcnt = 0;
    int         mlat = 5;
    bit         stuck = 1'b0;
    logic [7:0] mrd = '0;
    always @(posedge clk) begin
        if (!mbusy) begin
            if (q_start) begin
                mbusy <= 1'b1;
                mcnt  <= mlat;
            end
        end else if (!stuck) begin
            if (mcnt <= 1) mbusy <= 1'b0;
            else           mcnt  <= mcnt - 1;
        end
    end
    assign q_busy  = mbusy;
    assign q_cs    = ~mbusy;
    assign q_rdata = mrd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          f;
        logic [23:0] addr;
        bit          we;
        logic [7:0]  wd;
        logic [7:0]  rd;
        bit          e;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    bit          in_txn = 1'b0;
    int          n_done = 0;
    int          cs_err = 0;
    int          stab_err = 0;
    int          spur = 0;
    int          unexp = 0;
    int unsigned gnt_cyc = 0;
    logic [7:0]  exp_frd = '0;
    logic [7:0]  exp_drd = '0;

    task automatic push(input bit f, input logic [15:0] a, input bit we,
                        input logic [7:0] wd, input logic [7:0] rd, input bit e);
        txn_t t;
        t.f    = f;
        t.addr = f ? {8'h00, a} : {8'h01, a};
        t.we   = f ? 1'b0 : we;
        t.wd   = wd;
        t.e    = e;
        if (f) begin
            exp_frd = e ? 8'hFF : rd;
            t.rd    = exp_frd;
        end else begin
            if (!we) exp_drd = e ? 8'hFF : rd;
            t.rd = exp_drd;
        end
        exp_q.push_back(t);
    endtask

    // Monitor: pops expectations at each grant, checks routing every cycle, checks results at valid.
    always @(negedge clk) begin
        if (rst) begin
            in_txn = 1'b0;
        end else begin
            if (!cs_rom && !cs_ram) cs_err++;
            if (!busy && (cs_rom !== 1'b1 || cs_ram !== 1'b1)) cs_err++;
            if (in_txn && busy) begin
                if (cs_rom !== (cur.f ? q_cs : 1'b1) || cs_ram !== (cur.f ? 1'b1 : q_cs)) cs_err++;
                if (q_addr !== cur.addr || q_write !== cur.we) stab_err++;
                if (cur.we && q_wdata !== cur.wd) stab_err++;
            end
            if (f_gnt || d_gnt) begin
                if (exp_q.size() == 0) begin
                    unexp++;
                end else begin
                    cur     = exp_q.pop_front();
                    in_txn  = 1'b1;
                    gnt_cyc = cyc;
                    chk("gnt_f", 32'(f_gnt), 32'(cur.f));
                    chk("gnt_d", 32'(d_gnt), 32'(!cur.f));
                    chk("q_addr", 32'(q_addr), 32'(cur.addr));
                    chk("q_write", 32'(q_write), 32'(cur.we));
                    if (cur.we) chk("q_wdata", 32'(q_wdata), 32'(cur.wd));
                end
            end
            if (f_valid || d_valid) begin
                if (!in_txn) begin
                    spur++;
                end else begin
                    chk("valid_f", 32'(f_valid), 32'(cur.f));
                    chk("valid_d", 32'(d_valid), 32'(!cur.f));
                    chk("err", 32'(err), 32'(cur.e));
                    chk(cur.f ? "f_data" : "d_rdata", 32'(cur.f ? f_data : d_rdata), 32'(cur.rd));
                    if (cur.e) chk("to_latency", cyc - gnt_cyc, 64);
                    in_txn = 1'b0;
                    n_done++;
                end
            end else if (err) begin
                spur++;
            end
        end
    end

    task automatic wait_model_idle(input string tag);
        int i;
        for (i = 0; i < 200 && q_busy; i++) @(negedge clk);
        chk(tag, 32'(q_busy), 0);
    endtask

    task automatic run_one(input bit f, input logic [15:0] a, input bit we, input logic [7:0] wd,
                           input logic [7:0] rd, input int lat, input bit stk);
        int base;
        bit got;
        push(f, a, we, wd, rd, stk);
        mrd   = rd;
        mlat  = lat;
        stuck = stk;
        base  = n_done;
        got   = 1'b0;
        @(negedge clk);
        if (f) begin
            f_req = 1'b1; f_addr = a;
        end else begin
            d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (f ? f_gnt : d_gnt) got = 1'b1;
        end
        f_req = 1'b0;
        d_req = 1'b0;
        chk("gnt_seen", 32'(got), 1);
        for (int i = 0; i < 200 && n_done == base; i++) @(negedge clk);
        chk("done_seen", n_done - base, 1);
        if (stk) begin
            stuck = 1'b0;
            wait_model_idle("model_release");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int gcount;
        bit got;
        logic [7:0] saved;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cs_rom", 32'(cs_rom), 1);
        chk("rst_cs_ram", 32'(cs_ram), 1);
        chk("rst_q_start", 32'(q_start), 0);
        chk("rst_gnt", 32'({f_gnt, d_gnt, f_valid, d_valid, err}), 0);
        chk("rst_q_addr", 32'(q_addr), 0);
        chk("rst_data", 32'({f_data, d_rdata, q_wdata, 7'd0, q_write}), 0);
        rst = 1'b0;

        run_one(1'b1, 16'h0012, 1'b0, 8'h00, 8'hA5, 5, 1'b0);
        run_one(1'b0, 16'h0044, 1'b0, 8'h00, 8'h5A, 3, 1'b0);
        run_one(1'b0, 16'h0300, 1'b1, 8'h3C, 8'h77, 5, 1'b0);

        // Contention with both requests held: D,D,D,D,F,D,D,D,D,F.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push(1'b1, 16'h0100, 1'b0, 8'h00, 8'h6B, 1'b0);
            else            push(1'b0, 16'h0200, 1'b0, 8'h00, 8'h6B, 1'b0);
        end
        mrd = 8'h6B; mlat = 3; stuck = 1'b0;
        base = n_done; gcount = 0;
        @(negedge clk);
        f_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 400 && gcount < 10; i++) begin
            @(negedge clk);
            if (f_gnt || d_gnt) gcount++;
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("cont_grants", gcount, 10);
        for (int i = 0; i < 400 && n_done < base + 10; i++) @(negedge clk);
        chk("cont_done", n_done - base, 10);

        // Read timeout, then a normal read, then a write timeout leaving d_rdata intact.
        run_one(1'b0, 16'h0055, 1'b0, 8'h00, 8'h11, 4, 1'b1);
        run_one(1'b0, 16'h0066, 1'b0, 8'h00, 8'hC3, 4, 1'b0);
        run_one(1'b0, 16'h0077, 1'b1, 8'h99, 8'h22, 4, 1'b1);

        // Reset while the fetch is in WAIT.
        saved = exp_frd;
        push(1'b1, 16'h0020, 1'b0, 8'h00, 8'hEE, 1'b0);
        exp_frd = saved;
        mrd = 8'hEE; mlat = 30; stuck = 1'b0;
        got = 1'b0;
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0020;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (f_gnt) got = 1'b1;
        end
        f_req = 1'b0;
        chk("rst_test_gnt", 32'(got), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cs", 32'({cs_rom, cs_ram}), 32'h3);
        chk("midrst_valid", 32'({f_valid, err}), 0);
        repeat (6) @(negedge clk);
        wait_model_idle("midrst_model");
        run_one(1'b1, 16'h0030, 1'b0, 8'h00, 8'h9E, 5, 1'b0);

        repeat (4) @(negedge clk);
        chk("cs_route_errors", cs_err, 0);
        chk("q_stability_errors", stab_err, 0);
        chk("spurious_pulses", spur, 0);
        chk("unexpected_grants", unexp, 0);
        chk("pending_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
